bird_ctrl: RTL and testbench
============================

Name: bird_ctrl

Overview:
- Per-frame motion and animation sequencer for the bird sprite renderer.
- Owns the bird game state (idle / play / fall / dead) and integrates gravity and flap impulses once per frame.
- Drives the renderer's pos_x, pos_y, angle and bird_status inputs. These outputs are stable for a whole frame and change only right after frame_tick (vblank).

Parameters:
START_X, 16'sd80, fixed horizontal position of the bird (px)
START_Y, 16'sd200, vertical position in IDLE and after restart (px)
GRAVITY, 12'sd6, added to velocity each frame (1/16 px/frame^2)
FLAP_VEL, -12'sd96, velocity loaded on a flap (1/16 px/frame)
MAX_VEL, 12'sd160, terminal falling velocity (1/16 px/frame)
GROUND_Y, 16'sd400, ground line (px)
BIRD_H, 16'sd48, bird height used for the ground test (px)
ANGLE_MIN, -8'sd20, most nose-up angle
ANGLE_MAX, 8'sd63, most nose-down angle; must be at most 63 (renderer ROM depth)
FLAP_DIV, 4, frames per wing animation step

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
frame_tick  in  1  one-cycle pulse per frame at vblank
flap  in  1  one-cycle flap request, may arrive at any cycle
start  in  1  one-cycle restart request
collide  in  1  level, pipe collision detected this frame
pos_x  out  16 signed  sprite x, constant START_X
pos_y  out  16 signed  sprite y, integer part of internal position
angle  out  8 signed  rotation; positive = nose down
bird_status  out  2  wing frame select: 0, 1 or 2
game_state  out  2  0=IDLE 1=PLAY 2=FALL 3=DEAD
alive  out  1  high in IDLE and PLAY

Behaviour:
- Reset values:
  - state IDLE, pos_y=START_Y, internal position START_Y*16, velocity 0.
  - angle 0, bird_status 0, wing counter 0, flap_pend 0, alive 1.
- Internal position: signed 20-bit fixed point with 4 fractional bits; pos_y = pos_fp[19:4].
- Velocity: signed 12-bit.
- flap_pend is set by flap in any cycle and cleared on the frame_tick that consumes it. A flap in the same cycle as frame_tick is consumed by that tick.
- All state, position, angle and animation updates happen only in the cycle of frame_tick. Outputs reflect the new values the following cycle (latency 1). Between ticks all outputs are held.
- Tick in IDLE:
  - If flap_pend: go to PLAY, vel=FLAP_VEL, pos+=FLAP_VEL.
  - Otherwise pos stays START_Y and angle stays 0.
- Tick in PLAY:
  - vel_n = flap_pend ? FLAP_VEL : min(vel+GRAVITY, MAX_VEL); pos += vel_n.
  - If collide: go to FALL. collide beats flap on the same tick; the flap is discarded and gravity is applied.
  - If the new pos_y < 0: clamp pos to 0 and set vel=0.
  - If new pos_y + BIRD_H >= GROUND_Y: pos_y = GROUND_Y - BIRD_H, vel=0, go to DEAD. This takes priority over the FALL transition.
- Tick in FALL:
  - Flaps are ignored and flap_pend is cleared.
  - Gravity integration as in PLAY.
  - Ground contact goes to DEAD.
- DEAD:
  - Everything frozen.
  - start (sampled on any cycle) arms a restart. At the next tick: IDLE with the reset values for pos, vel, angle and animation.
  - start in any other state is ignored.
- Angle (PLAY and FALL): angle = clamp(vel>>>2, ANGLE_MIN, ANGLE_MAX), computed from vel_n. It is 0 in IDLE and frozen in DEAD.
- Wing animation:
  - In IDLE and PLAY, the counter increments each tick.
  - On reaching FLAP_DIV-1 it wraps and bird_status steps through the sequence 0,1,2,1,0...
  - Frozen in FALL and DEAD. bird_status is never 3.
- Asynchronous reset mid-frame returns to the reset values immediately and clears any pending flap or start.

Optional Feature:
BIRD_CTRL_BOB_EN:
- Defined: in IDLE, pos_y follows a triangle wave START_Y-2 .. START_Y+2 that steps 1 px every 2 ticks, starting upward.
- The IDLE->PLAY transition starts from the current bobbed position.
- Undefined: IDLE pos_y is constant START_Y.

Test Plan:
- Reset, then 3 ticks with no input -> game_state 0, pos_y 200, angle 0, alive 1 (BOB undefined).
- flap pulse, then tick -> state PLAY, pos_y 194, angle -20. Next tick -> pos_y 188, vel -90.
- PLAY with no flaps for 40 ticks -> vel saturates at 160, angle 40. Continue until pos_y reaches 352 -> state DEAD, pos_y 352, alive 0, outputs frozen afterwards.
- In PLAY, assert collide and flap in the same tick -> state FALL, flap ignored, vel = previous+6. Later flaps have no effect.
- In DEAD, pulse start mid-frame, then tick -> state IDLE, pos_y 200, angle 0, bird_status 0.
- Assert rstn low mid-frame while in FALL -> outputs return to reset values asynchronously, with no tick required.

Source files
------------

// File: rtl/bird_ctrl.sv
// Bird motion/animation sequencer: game FSM, fixed-point gravity/flap integration, wing frames.
// Optional IDLE bobbing animation is enabled by defining BIRD_CTRL_BOB_EN.
module bird_ctrl #(
   parameter logic signed [15:0] START_X   = 16'sd80,
   parameter logic signed [15:0] START_Y   = 16'sd200,
   parameter logic signed [11:0] GRAVITY   = 12'sd6,
   parameter logic signed [11:0] FLAP_VEL  = -12'sd96,
   parameter logic signed [11:0] MAX_VEL   = 12'sd160,
   parameter logic signed [15:0] GROUND_Y  = 16'sd400,
   parameter logic signed [15:0] BIRD_H    = 16'sd48,
   parameter logic signed [7:0]  ANGLE_MIN = -8'sd20,
   parameter logic signed [7:0]  ANGLE_MAX = 8'sd63,
   parameter int                 FLAP_DIV  = 4
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               frame_tick,
   input  logic               flap,
   input  logic               start,
   input  logic               collide,
   output logic signed [15:0] pos_x,
   output logic signed [15:0] pos_y,
   output logic signed [7:0]  angle,
   output logic [1:0]         bird_status,
   output logic [1:0]         game_state,
   output logic               alive
);

   // flap/start are single-cycle pulses latched until the next frame_tick;
   // a pulse coincident with frame_tick is consumed by that same tick.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PLAY = 2'd1,
      ST_FALL = 2'd2,
      ST_DEAD = 2'd3
   } state_e;

   localparam int                 CNT_W    = (FLAP_DIV > 2) ? $clog2(FLAP_DIV) : 1;
   localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(FLAP_DIV - 1);
   localparam logic signed [19:0] START_FP = {START_Y, 4'h0};
   localparam logic signed [15:0] LAND_Y   = GROUND_Y - BIRD_H;
   localparam logic signed [19:0] LAND_FP  = {LAND_Y, 4'h0};

   state_e             state_q, state_d;
   logic signed [19:0] pos_q, pos_d, pos_sum;
   logic signed [11:0] vel_q, vel_d, vel_n, vel_grav, vel_shr;
   logic signed [12:0] vel_inc;
   logic signed [7:0]  angle_q, angle_d;
   logic [CNT_W-1:0]   wing_cnt_q, wing_cnt_d;
   logic [1:0]         wing_ph_q, wing_ph_d;
   logic               flap_pend_q, flap_pend_d;
   logic               start_pend_q, start_pend_d;
   logic               flap_eff, start_eff;
   logic               integrate, animate;
   logic signed [15:0] idle_y;

`ifdef BIRD_CTRL_BOB_EN
   logic signed [2:0]  bob_off_q, bob_off_d;
   logic               bob_up_q, bob_up_d;
   logic               bob_half_q, bob_half_d;
`endif

   assign flap_eff  = flap_pend_q | flap;
   assign start_eff = start_pend_q | start;

   // Gravity step with terminal-velocity saturation, one bit wider to avoid wrap.
   assign vel_inc  = {vel_q[11], vel_q} + {GRAVITY[11], GRAVITY};
   assign vel_grav = (vel_inc > $signed({MAX_VEL[11], MAX_VEL})) ? MAX_VEL : vel_inc[11:0];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= ST_IDLE;
         pos_q        <= START_FP;
         vel_q        <= '0;
         angle_q      <= '0;
         wing_cnt_q   <= '0;
         wing_ph_q    <= '0;
         flap_pend_q  <= 1'b0;
         start_pend_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pos_q        <= pos_d;
         vel_q        <= vel_d;
         angle_q      <= angle_d;
         wing_cnt_q   <= wing_cnt_d;
         wing_ph_q    <= wing_ph_d;
         flap_pend_q  <= flap_pend_d;
         start_pend_q <= start_pend_d;
      end
   end

`ifdef BIRD_CTRL_BOB_EN
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         bob_off_q  <= '0;
         bob_up_q   <= 1'b1;
         bob_half_q <= 1'b0;
      end else begin
         bob_off_q  <= bob_off_d;
         bob_up_q   <= bob_up_d;
         bob_half_q <= bob_half_d;
      end
   end
`endif

   always_comb begin
      state_d      = state_q;
      pos_d        = pos_q;
      vel_d        = vel_q;
      angle_d      = angle_q;
      wing_cnt_d   = wing_cnt_q;
      wing_ph_d    = wing_ph_q;
      flap_pend_d  = flap_pend_q | flap;
      start_pend_d = start_pend_q | (start && (state_q == ST_DEAD));
      vel_n        = vel_q;
      integrate    = 1'b0;
      animate      = 1'b0;
      idle_y       = START_Y;
      pos_sum      = pos_q;
      vel_shr      = '0;
`ifdef BIRD_CTRL_BOB_EN
      bob_off_d    = bob_off_q;
      bob_up_d     = bob_up_q;
      bob_half_d   = bob_half_q;
`endif

      if (frame_tick) begin
         flap_pend_d = 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               animate = 1'b1;
               if (flap_eff) begin
                  state_d   = ST_PLAY;
                  vel_n     = FLAP_VEL;
                  integrate = 1'b1;
               end else begin
`ifdef BIRD_CTRL_BOB_EN
                  // Triangle wave: one pixel every second tick, upward (smaller y) first.
                  bob_half_d = ~bob_half_q;
                  if (bob_half_q) begin
                     bob_off_d = bob_up_q ? (bob_off_q - 3'sd1) : (bob_off_q + 3'sd1);
                     if (bob_off_d == -3'sd2)
                        bob_up_d = 1'b0;
                     else if (bob_off_d == 3'sd2)
                        bob_up_d = 1'b1;
                  end
                  idle_y = START_Y + {{13{bob_off_d[2]}}, bob_off_d};
`endif
                  pos_d   = {idle_y, 4'h0};
                  vel_d   = '0;
                  angle_d = '0;
               end
            end
            ST_PLAY: begin
               animate   = 1'b1;
               integrate = 1'b1;
               if (collide) begin
                  state_d = ST_FALL;
                  vel_n   = vel_grav;
               end else begin
                  vel_n = flap_eff ? FLAP_VEL : vel_grav;
               end
            end
            ST_FALL: begin
               integrate = 1'b1;
               vel_n     = vel_grav;
            end
            ST_DEAD: begin
               if (start_eff) begin
                  state_d      = ST_IDLE;
                  pos_d        = START_FP;
                  vel_d        = '0;
                  angle_d      = '0;
                  wing_cnt_d   = '0;
                  wing_ph_d    = '0;
                  start_pend_d = 1'b0;
`ifdef BIRD_CTRL_BOB_EN
                  bob_off_d    = '0;
                  bob_up_d     = 1'b1;
                  bob_half_d   = 1'b0;
`endif
               end
            end
            default: ;
         endcase

         if (integrate) begin
            pos_sum = pos_q + {{8{vel_n[11]}}, vel_n};
            vel_shr = vel_n >>> 2;
            vel_d   = vel_n;
            pos_d   = pos_sum;
            if (vel_shr < $signed({{4{ANGLE_MIN[7]}}, ANGLE_MIN}))
               angle_d = ANGLE_MIN;
            else if (vel_shr > $signed({{4{ANGLE_MAX[7]}}, ANGLE_MAX}))
               angle_d = ANGLE_MAX;
            else
               angle_d = vel_shr[7:0];
            if (pos_sum[19]) begin
               pos_d = '0;
               vel_d = '0;
            end
            // Ground contact wins over a collide-driven move to FALL.
            if ($signed(pos_sum[19:4]) >= LAND_Y) begin
               pos_d   = LAND_FP;
               vel_d   = '0;
               state_d = ST_DEAD;
            end
         end

         if (animate) begin
            if (wing_cnt_q == CNT_LAST) begin
               wing_cnt_d = '0;
               wing_ph_d  = wing_ph_q + 2'd1;
            end else begin
               wing_cnt_d = wing_cnt_q + 1'b1;
            end
         end
      end
   end

   // Wing phase 0,1,2,3 maps to frames 0,1,2,1 so frame 3 never appears.
   assign bird_status = (wing_ph_q == 2'd3) ? 2'd1 : wing_ph_q;
   assign pos_x       = START_X;
   assign pos_y       = pos_q[19:4];
   assign angle       = angle_q;
   assign game_state  = state_q;
   assign alive       = (state_q == ST_IDLE) || (state_q == ST_PLAY);

endmodule

// File: tb/tb_bird_ctrl.sv
// Self-checking bench for bird_ctrl (default build, bobbing disabled) against a frame-level model.
module tb_bird_ctrl;

   logic               clk = 1'b0;
   logic               rstn = 1'b0;
   logic               frame_tick = 1'b0;
   logic               flap = 1'b0;
   logic               start = 1'b0;
   logic               collide = 1'b0;
   logic signed [15:0] pos_x, pos_y;
   logic signed [7:0]  angle;
   logic [1:0]         bird_status, game_state;
   logic               alive;
   logic [28:0]        dut_vec;

   always #5 clk = ~clk;

   bird_ctrl dut (
      .clk(clk), .rstn(rstn), .frame_tick(frame_tick), .flap(flap), .start(start),
      .collide(collide), .pos_x(pos_x), .pos_y(pos_y), .angle(angle),
      .bird_status(bird_status), .game_state(game_state), .alive(alive)
   );

   assign dut_vec = {game_state, pos_y, angle, bird_status, alive};

   int          checks = 0;
   int          failures = 0;
   logic [28:0] exp_q[$];
   logic [28:0] obs_q[$];
   logic [28:0] e, o;

   // Model: position in 1/16 px, velocity in 1/16 px/frame, anim = number of animated ticks.
   int m_state, m_pos, m_vel, m_angle, m_anim;
   bit m_flap_pend, m_start_pend;

   function automatic int floor_div4(int v);
      return (v >= 0) ? v / 4 : -((-v + 3) / 4);
   endfunction

   function automatic int fall_vel(int v);
      return (v + 6 > 160) ? 160 : v + 6;
   endfunction

   function automatic void m_reset();
      m_state = 0; m_pos = 200 * 16; m_vel = 0; m_angle = 0; m_anim = 0;
      m_flap_pend = 0; m_start_pend = 0;
   endfunction

   function automatic void m_apply(int nv);
      int a;
      m_pos = m_pos + nv;
      m_vel = nv;
      a = floor_div4(nv);
      m_angle = (a < -20) ? -20 : (a > 63) ? 63 : a;
      if (m_pos < 0) begin m_pos = 0; m_vel = 0; end
      if (m_pos / 16 + 48 >= 400) begin m_pos = 352 * 16; m_vel = 0; m_state = 3; end
   endfunction

   function automatic logic [28:0] m_vec();
      int          seq[4];
      logic [1:0]  st;
      logic [15:0] py;
      logic [7:0]  an;
      logic [1:0]  gs;
      seq = '{0, 1, 2, 1};
      st = 2'(seq[(m_anim / 4) % 4]);
      py = 16'(m_pos / 16);
      an = 8'(m_angle);
      gs = 2'(m_state);
      return {gs, py, an, st, (m_state <= 1)};
   endfunction

   task automatic drive_cycle(input bit tk, input bit fl, input bit st, input bit co);
      bit fe;
      @(negedge clk);
      frame_tick = tk; flap = fl; start = st; collide = co;
      @(posedge clk);
      fe = m_flap_pend | fl;
      if (tk) begin
         case (m_state)
            0: begin
               m_anim++;
               if (fe) begin m_state = 1; m_apply(-96); end
               else begin m_pos = 200 * 16; m_vel = 0; m_angle = 0; end
            end
            1: begin
               m_anim++;
               if (co) begin m_state = 2; m_apply(fall_vel(m_vel)); end
               else m_apply(fe ? -96 : fall_vel(m_vel));
            end
            2: m_apply(fall_vel(m_vel));
            default: if (m_start_pend || st) m_reset();
         endcase
         m_flap_pend = 0;
      end else begin
         m_flap_pend = fe;
         if (m_state == 3 && st) m_start_pend = 1;
      end
      #1;
      frame_tick = 0; flap = 0; start = 0; collide = 0;
      exp_q.push_back(m_vec());
      obs_q.push_back(dut_vec);
   endtask

   task automatic play_frame(input int len, input int flap_at, input int start_at, input bit co);
      for (int i = 0; i < len; i++)
         drive_cycle(i == len - 1, i == flap_at, i == start_at, co);
   endtask

   task automatic test_reset();
      rstn = 0;
      repeat (2) @(negedge clk);
      m_reset();
      checks++;
      if (dut_vec !== m_vec()) begin
         failures++; $display("FAIL reset_vals got=%h exp=%h", dut_vec, m_vec());
      end
      checks++;
      if (pos_x !== 16'sd80) begin failures++; $display("FAIL pos_x got=%0d exp=80", pos_x); end
      @(negedge clk) rstn = 1;
      repeat (3) play_frame(3, -1, -1, 0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
         if (o !== e) begin failures++; $display("FAIL idle_hold got=%h exp=%h", o, e); end
      end
      checks++;
      if (game_state !== 2'd0 || pos_y !== 16'sd200 || angle !== 8'sd0 || alive !== 1'b1) begin
         failures++; $display("FAIL idle_const st=%0d y=%0d ang=%0d alive=%0d exp 0/200/0/1",
                              game_state, pos_y, angle, alive);
      end
   endtask

   task automatic test_first_flap();
      play_frame(3, 1, -1, 0);
      checks++;
      if (game_state !== 2'd1 || pos_y !== 16'sd194 || angle !== -8'sd20) begin
         failures++; $display("FAIL first_flap st=%0d y=%0d ang=%0d exp 1/194/-20", game_state, pos_y, angle);
      end
      play_frame(3, -1, -1, 0);
      checks++;
      if (pos_y !== 16'sd188 || angle !== -8'sd20) begin
         failures++; $display("FAIL second_tick y=%0d ang=%0d exp 188/-20", pos_y, angle);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
         if (o !== e) begin failures++; $display("FAIL first_flap_seq got=%h exp=%h", o, e); end
      end
   endtask

   task automatic test_random_play();
      for (int f = 0; f < 60 && m_state != 3; f++) begin
         int len, fa, sa;
         len = $urandom_range(1, 5);
         fa = ((m_pos / 16) > 260 || $urandom_range(0, 5) == 0) ? $urandom_range(0, len - 1) : -1;
         sa = ($urandom_range(0, 7) == 0) ? $urandom_range(0, len - 1) : -1;
         play_frame(len, fa, sa, 0);
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL random_play f=%0d got=%h exp=%h", f, o, e); end
         end
      end
   endtask

   task automatic test_ceiling();
      for (int f = 0; f < 45; f++) play_frame(2, 0, -1, 0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
         if (o !== e) begin failures++; $display("FAIL ceiling got=%h exp=%h", o, e); end
      end
      checks++;
      if (game_state !== 2'd1 || pos_y !== 16'sd0) begin
         failures++; $display("FAIL ceiling_clamp st=%0d y=%0d exp 1/0", game_state, pos_y);
      end
   endtask

   task automatic test_ground();
      int n;
      n = 0;
      while (m_state != 3 && n < 200) begin
         play_frame(2, -1, -1, 0);
         n++;
         if (m_state == 1 && m_vel == 160) begin
            checks++;
            if (angle !== 8'sd40) begin failures++; $display("FAIL sat_angle got=%0d exp=40", angle); end
         end
      end
      checks++;
      if (game_state !== 2'd3 || pos_y !== 16'sd352 || alive !== 1'b0) begin
         failures++; $display("FAIL ground st=%0d y=%0d alive=%0d exp 3/352/0", game_state, pos_y, alive);
      end
      for (int f = 0; f < 5; f++) play_frame(3, f % 3, -1, 0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
         if (o !== e) begin failures++; $display("FAIL ground_seq got=%h exp=%h", o, e); end
      end
   endtask

   task automatic test_restart();
      play_frame(4, -1, 1, 0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
         if (o !== e) begin failures++; $display("FAIL restart_seq got=%h exp=%h", o, e); end
      end
      checks++;
      if (game_state !== 2'd0 || pos_y !== 16'sd200 || angle !== 8'sd0 || bird_status !== 2'd0) begin
         failures++; $display("FAIL restart st=%0d y=%0d ang=%0d ws=%0d exp 0/200/0/0",
                              game_state, pos_y, angle, bird_status);
      end
   endtask

   task automatic test_collide();
      play_frame(2, 0, -1, 0);
      for (int f = 0; f < 6; f++) play_frame($urandom_range(1, 4), ($urandom_range(0, 1) == 1) ? 0 : -1, -1, 0);
      play_frame(3, 2, -1, 1);
      checks++;
      if (game_state !== 2'd2) begin failures++; $display("FAIL collide_state got=%0d exp=2", game_state); end
      for (int f = 0; f < 3; f++) play_frame(3, f, -1, 0);
      checks++;
      if (game_state !== 2'd2) begin failures++; $display("FAIL fall_hold got=%0d exp=2", game_state); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
         if (o !== e) begin failures++; $display("FAIL collide_seq got=%h exp=%h", o, e); end
      end
   endtask

   task automatic test_async_reset();
      drive_cycle(0, 1, 0, 0);
      @(negedge clk);
      #2 rstn = 0;
      #1;
      m_reset();
      exp_q.delete(); obs_q.delete();
      checks++;
      if (dut_vec !== m_vec()) begin
         failures++; $display("FAIL async_reset got=%h exp=%h", dut_vec, m_vec());
      end
      @(negedge clk) rstn = 1;
      play_frame(2, -1, -1, 0);
      play_frame(2, -1, -1, 0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
         if (o !== e) begin failures++; $display("FAIL post_reset got=%h exp=%h", o, e); end
      end
   endtask

   task automatic test_back_to_back();
      int n;
      for (int f = 0; f < 4; f++) play_frame(1, 0, -1, 0);
      play_frame(1, -1, -1, 1);
      n = 0;
      while (m_state != 3 && n < 200) begin
         play_frame(1, n % 2, -1, 0);
         n++;
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
         if (o !== e) begin failures++; $display("FAIL back_to_back got=%h exp=%h", o, e); end
      end
      checks++;
      if (game_state !== 2'd3) begin failures++; $display("FAIL fall_ground got=%0d exp=3", game_state); end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      m_reset();
      test_reset();
      test_first_flap();
      test_random_play();
      if (m_state == 3) test_restart();
      if (m_state == 0) play_frame(2, 0, -1, 0);
      test_ceiling();
      test_ground();
      test_restart();
      test_collide();
      test_async_reset();
      test_back_to_back();
      test_restart();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
